// File: rtl/id_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// id_hazard_ctrl
//
// Decode-stage issue controller for the five-stage RV32I pipeline. It owns
// the IF/ID register and sequences instructions into the ID/EX register. It
// inserts bubbles on read-after-write hazards against older in-flight
// instructions, applies branch flushes and EX backpressure, and counts hazard
// bubble cycles.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   if_valid   fetch presents an instruction
//   if_instr   fetched instruction (32)
//   if_pc      PC of the fetched instruction (32)
//   if_ready   ID accepts fetch this cycle (combinational)
//   ex_ready   EX accepts a new ID/EX entry this cycle
//   flush      taken branch/jump resolved in EX: kill younger instructions
//   ex_valid   ID/EX entry valid (registered)
//   ex_instr   ID/EX instruction (registered, 32)
//   ex_pc      ID/EX PC (registered, 32)
//   stall_cnt  hazard bubble cycles, wraps (registered, 32)
//
// Build option
//   ID_FORWARD_EN  defined: EX->EX and MEM->EX bypass exists, so only a
//                  load in ID/EX feeding the ID instruction stalls (1 bubble).
//                  undefined: any valid writer in ID/EX or MEM whose rd is
//                  read by the ID instruction stalls until it has left MEM.
// ---------------------------------------------------------------------------
module id_hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic        if_ready,
  input  logic        ex_ready,
  input  logic        flush,
  output logic        ex_valid,
  output logic [31:0] ex_instr,
  output logic [31:0] ex_pc,
  output logic [31:0] stall_cnt
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  // What the pipeline does this cycle, in priority order.
  typedef enum logic [1:0] {
    ACT_FLUSH,
    ACT_HOLD,
    ACT_BUBBLE,
    ACT_ADV
  } act_t;

  function automatic logic writes_rd(input logic [6:0] op);
    logic w;
    w = 1'b0;
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_OP: w = 1'b1;
      default: w = 1'b0;
    endcase
    return w;
  endfunction

  function automatic logic reads_rs1(input logic [6:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_OP: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic reads_rs2(input logic [6:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_BRANCH, OP_STORE, OP_OP: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // IF/ID register
  logic        id_vld;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  // MEM shadow: only what is needed to see an older writer one stage further
  logic        mem_vld;
  logic [4:0]  mem_rd;
  logic        mem_wr;

  // ID-side decode
  logic [6:0]  id_op;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use1;
  logic        id_use2;

  // EX-side decode; ex_wr already excludes rd = x0 so x0 never matches
  logic [6:0]  ex_op;
  logic [4:0]  ex_rd;
  logic        ex_wr;

  logic        match_ex;
  logic        match_mem;
  logic        hazard;
  act_t        act;

  assign id_op   = id_instr[6:0];
  assign id_rs1  = id_instr[19:15];
  assign id_rs2  = id_instr[24:20];
  assign id_use1 = reads_rs1(id_op);
  assign id_use2 = reads_rs2(id_op);

  assign ex_op   = ex_instr[6:0];
  assign ex_rd   = ex_instr[11:7];
  assign ex_wr   = writes_rd(ex_op) & (ex_rd != 5'd0);

  assign match_ex  = (id_use1 & (id_rs1 == ex_rd))  | (id_use2 & (id_rs2 == ex_rd));
  assign match_mem = (id_use1 & (id_rs1 == mem_rd)) | (id_use2 & (id_rs2 == mem_rd));

  // The register file writes through, so WB never needs to be checked.
`ifdef ID_FORWARD_EN
  assign hazard = id_vld & ex_valid & (ex_op == OP_LOAD) & ex_wr & match_ex;
`else
  assign hazard = id_vld & ((ex_valid & ex_wr & match_ex) |
                            (mem_vld  & mem_wr & match_mem));
`endif

  // Flush overrides everything, including an illegal flush under backpressure.
  assign if_ready = flush | (ex_ready & ~hazard);

  always_comb begin
    act = ACT_ADV;
    if (flush) begin
      act = ACT_FLUSH;
    end else if (!ex_ready) begin
      act = ACT_HOLD;
    end else if (hazard) begin
      act = ACT_BUBBLE;
    end
  end

  // ---- IF/ID -> ID/EX -> MEM shadow: control and reset-visible state ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_vld    <= 1'b0;
      ex_valid  <= 1'b0;
      ex_instr  <= 32'd0;
      ex_pc     <= 32'd0;
      mem_vld   <= 1'b0;
      mem_rd    <= 5'd0;
      mem_wr    <= 1'b0;
      stall_cnt <= 32'd0;
    end else begin
      case (act)
        ACT_FLUSH: begin
          id_vld   <= 1'b0;
          ex_valid <= 1'b0;
          mem_vld  <= ex_valid;
          mem_rd   <= ex_rd;
          mem_wr   <= ex_wr;
        end
        ACT_HOLD: begin
        end
        ACT_BUBBLE: begin
          ex_valid  <= 1'b0;
          mem_vld   <= ex_valid;
          mem_rd    <= ex_rd;
          mem_wr    <= ex_wr;
          stall_cnt <= stall_cnt + 32'd1;
        end
        default: begin
          ex_valid <= id_vld;
          ex_instr <= id_instr;
          ex_pc    <= id_pc;
          mem_vld  <= ex_valid;
          mem_rd   <= ex_rd;
          mem_wr   <= ex_wr;
          id_vld   <= if_valid;
        end
      endcase
    end
  end

  // ---- fetch -> IF/ID data (qualified by id_vld, so no reset needed) ----
  always_ff @(posedge clk) begin
    if (act == ACT_ADV) begin
      id_instr <= if_instr;
      id_pc    <= if_pc;
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
module tb_id_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        ex_ready;
  logic        flush;
  logic        ex_valid;
  logic [31:0] ex_instr;
  logic [31:0] ex_pc;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  id_hazard_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_valid  (if_valid),
    .if_instr  (if_instr),
    .if_pc     (if_pc),
    .if_ready  (if_ready),
    .ex_ready  (ex_ready),
    .flush     (flush),
    .ex_valid  (ex_valid),
    .ex_instr  (ex_instr),
    .ex_pc     (ex_pc),
    .stall_cnt (stall_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Slots: 0 = ID, 1 = EX, 2 = MEM. Each slot is a whole instruction.
  typedef struct packed {
    bit        v;
    bit [31:0] instr;
    bit [31:0] pc;
  } ent_t;

  ent_t      m_pipe [3];
  bit [31:0] m_cnt;

  function automatic bit m_writes(input bit [31:0] i);
    bit [6:0] op;
    op = i[6:0];
    return (op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                       7'b0000011, 7'b0010011, 7'b0110011}) && (i[11:7] != 5'd0);
  endfunction

  function automatic bit m_reads1(input bit [31:0] i);
    return i[6:0] inside {7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011,
                          7'b0010011, 7'b0110011};
  endfunction

  function automatic bit m_reads2(input bit [31:0] i);
    return i[6:0] inside {7'b1100011, 7'b0100011, 7'b0110011};
  endfunction

  // Does younger instruction y read a register that older o is about to write?
  function automatic bit m_depends(input ent_t y, input ent_t o);
    bit [4:0] rd;
    rd = o.instr[11:7];
    if (!o.v || !m_writes(o.instr)) return 1'b0;
    return (m_reads1(y.instr) && (y.instr[19:15] == rd)) ||
           (m_reads2(y.instr) && (y.instr[24:20] == rd));
  endfunction

  function automatic bit m_hazard();
    if (!m_pipe[0].v) return 1'b0;
`ifdef ID_FORWARD_EN
    return (m_pipe[1].instr[6:0] == 7'b0000011) && m_depends(m_pipe[0], m_pipe[1]);
`else
    for (int k = 1; k <= 2; k++) begin
      if (m_depends(m_pipe[0], m_pipe[k])) return 1'b1;
    end
    return 1'b0;
`endif
  endfunction

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic m_step();
    bit hz;
    hz = m_hazard();
    if (!rst_n) begin
      m_pipe[0].v     = 1'b0;
      m_pipe[1]       = '0;
      m_pipe[2].v     = 1'b0;
      m_cnt           = 32'd0;
    end else if (flush) begin
      m_pipe[2]   = m_pipe[1];
      m_pipe[1].v = 1'b0;
      m_pipe[0].v = 1'b0;
    end else if (ex_ready) begin
      m_pipe[2] = m_pipe[1];
      if (hz) begin
        m_pipe[1].v = 1'b0;
        m_cnt++;
      end else begin
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = {if_valid, if_instr, if_pc};
      end
    end
  endtask

  // One cycle: outputs are compared at negedge, then the model steps, then
  // the DUT clock edge; returns 1 time unit after the posedge.
  task automatic tick();
    @(negedge clk);
    #1;
    m_step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("ex_valid", {31'd0, ex_valid}, {31'd0, m_pipe[1].v});
        if (m_pipe[1].v) begin
          check("ex_instr", ex_instr, m_pipe[1].instr);
          check("ex_pc", ex_pc, m_pipe[1].pc);
        end
        check("stall_cnt", stall_cnt, m_cnt);
        check("if_ready", {31'd0, if_ready}, {31'd0, flush | (ex_ready & ~m_hazard())});
      end
    end
  end

  // ---------------- directed helpers ----------------
  bit [31:0] prog [8];

  task automatic do_reset();
    rst_n    = 1'b0;
    if_valid = 1'b0;
    if_instr = 32'd0;
    if_pc    = 32'd0;
    flush    = 1'b0;
    ex_ready = 1'b1;
    tick();
    rst_n = 1'b1;
  endtask

  // Feed prog[0..n-1] at full rate, optionally holding ex_ready low for three
  // cycles from cycle hold_at. Reports EX transfers in order and the number
  // of empty EX cycles between the first and the last transfer.
  task automatic run_seq(input int n, input int hold_at,
                         output int bubbles, output int order_err, output int got);
    int  idx;
    int  cyc;
    bit  started;
    idx = 0; cyc = 0; started = 1'b0;
    bubbles = 0; order_err = 0; got = 0;
    while (got < n && cyc < 40) begin
      if_valid = (idx < n);
      if_instr = (idx < n) ? prog[idx] : 32'd0;
      if_pc    = 32'h100 + 32'(idx) * 32'd4;
      flush    = 1'b0;
      ex_ready = !(hold_at >= 0 && cyc >= hold_at && cyc < hold_at + 3);
      #1;
      if (!ex_ready) check("bp_if_ready", {31'd0, if_ready}, 32'd0);
      if (ex_ready && ex_valid) begin
        if (ex_instr !== prog[got] || ex_pc !== 32'h100 + 32'(got) * 32'd4) order_err++;
        got++;
        started = 1'b1;
      end else if (ex_ready && !ex_valid && started) begin
        bubbles++;
      end
      if (if_valid && if_ready) idx++;
      tick();
      cyc++;
    end
    if_valid = 1'b0;
    ex_ready = 1'b1;
  endtask

  task automatic pair_test(input string name, input int n, input int exp_bub);
    int b, oe, g;
    do_reset();
    run_seq(n, -1, b, oe, g);
    check({name, "_got"}, 32'(g), 32'(n));
    check({name, "_order"}, 32'(oe), 32'd0);
    check({name, "_bubbles"}, 32'(b), 32'(exp_bub));
    check({name, "_stall_cnt"}, stall_cnt, 32'(exp_bub));
  endtask

  function automatic bit [31:0] rand_instr();
    bit [31:0] i;
    i = $urandom;
    case ($urandom_range(0, 9))
      0: i[6:0] = 7'b0110111;
      1: i[6:0] = 7'b0010111;
      2: i[6:0] = 7'b1101111;
      3: i[6:0] = 7'b1100111;
      4: i[6:0] = 7'b1100011;
      5: i[6:0] = 7'b0000011;
      6: i[6:0] = 7'b0100011;
      7: i[6:0] = 7'b0010011;
      8: i[6:0] = 7'b0110011;
      default: i[6:0] = 7'b1110011;
    endcase
    i[11:7]  = 5'($urandom_range(0, 3));
    i[19:15] = 5'($urandom_range(0, 3));
    i[24:20] = 5'($urandom_range(0, 3));
    return i;
  endfunction

  // ---------------- main stimulus ----------------
  initial begin
    int b, oe, g;
    int adj_bub, gap_bub, lu_bub;
    bit pre_ok;

`ifdef ID_FORWARD_EN
    adj_bub = 0; gap_bub = 0; lu_bub = 1;
`else
    adj_bub = 2; gap_bub = 1; lu_bub = 2;
`endif

    do_reset();
    chk_en = 1'b1;
    check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_ex_instr", ex_instr, 32'd0);
    check("rst_ex_pc", ex_pc, 32'd0);
    check("rst_stall_cnt", stall_cnt, 32'd0);
    check("rst_if_ready", {31'd0, if_ready}, 32'd1);

    // add x6,x5,x7 ; addi x8,x6,1
    prog[0] = 32'h00728333; prog[1] = 32'h00130413;
    pair_test("raw_adj", 2, adj_bub);
    // same pair with add x9,x0,x0 between
    prog[0] = 32'h00728333; prog[1] = 32'h000004B3; prog[2] = 32'h00130413;
    pair_test("raw_gap", 3, gap_bub);
    // lw x5,0(x1) ; add x6,x5,x7
    prog[0] = 32'h0000A283; prog[1] = 32'h00728333;
    pair_test("load_use", 2, lu_bub);
    // lw x0,0(x1) ; add x6,x0,x0
    prog[0] = 32'h0000A003; prog[1] = 32'h00000333;
    pair_test("x0_dep", 2, 0);
    // lw x5,0(x1) ; lui x5,1
    prog[0] = 32'h0000A283; prog[1] = 32'h000012B7;
    pair_test("lui_after_ld", 2, 0);

    // Backpressure on an independent stream addi xk,x0,k
    do_reset();
    for (int k = 0; k < 6; k++) prog[k] = (32'(k + 1) << 20) | (32'(k + 1) << 7) | 32'h13;
    run_seq(6, 3, b, oe, g);
    check("bp_got", 32'(g), 32'd6);
    check("bp_order", 32'(oe), 32'd0);
    check("bp_bubbles", 32'(b), 32'd0);
    check("bp_stall_cnt", stall_cnt, 32'd0);

    // Flush with IF/ID valid and a fetch presented
    do_reset();
    if_valid = 1'b1; if_instr = 32'h00000333; if_pc = 32'h200;
    tick();
    if_instr = 32'h000004B3; if_pc = 32'h204; flush = 1'b1;
    #1;
    check("flush_if_ready", {31'd0, if_ready}, 32'd1);
    tick();
    flush = 1'b0;
    check("flush_ex_valid", {31'd0, ex_valid}, 32'd0);
    if_instr = 32'h00100093; if_pc = 32'h208;
    tick();
    if_valid = 1'b0;
    check("flush_gap_valid", {31'd0, ex_valid}, 32'd0);
    tick();
    check("flush_y_valid", {31'd0, ex_valid}, 32'd1);
    check("flush_y_instr", ex_instr, 32'h00100093);
    check("flush_y_pc", ex_pc, 32'h208);
    tick();
    check("flush_after_valid", {31'd0, ex_valid}, 32'd0);

    // Reset in the middle of a dependent load chain: lw x5,0(x5)
    do_reset();
    pre_ok = 1'b0;
    if_valid = 1'b1; if_instr = 32'h0002A283; if_pc = 32'h300;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (stall_cnt >= 32'd5 && ex_valid) begin
        pre_ok = 1'b1;
        break;
      end
      tick();
    end
    check("mid_rst_pre", {31'd0, pre_ok}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; if_valid = 1'b0;
    check("mid_rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("mid_rst_stall_cnt", stall_cnt, 32'd0);
    tick();
    check("mid_rst_drained", {31'd0, ex_valid}, 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst_n    = ($urandom_range(0, 299) != 0);
      if_valid = $urandom_range(0, 3) != 0;
      if_instr = rand_instr();
      if_pc    = $urandom;
      ex_ready = $urandom_range(0, 7) != 0;
      flush    = $urandom_range(0, 24) == 0;
      tick();
    end
    flush = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
